mul_dispatcher: RTL and testbench

- Upstream command stage for the 32x32 Booth multiplier.
- Buffers operand pairs arriving over a valid/ready interface in a small FIFO and launches them one at a time on the multiplier's op_start/op_done/op_clear handshake.
- Captures each 64-bit product and presents it downstream over a valid/ready interface.
- Guards every operation with a watchdog timeout.

---
 rtl/mul_disp_pkg.sv | 21 ++
 rtl/mul_disp_fifo.sv | 72 +++++++
 rtl/mul_dispatcher.sv | 142 ++++++++++++++
 tb/tb_mul_dispatcher.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_disp_pkg.sv
// Shared constants and types for the Booth-multiplier command dispatcher.
// FSM encodings stay as plain 2-bit constants so legacy tooling can decode them.
package mul_disp_pkg;

  localparam int OP_W        = 32;
  localparam int RES_W       = 64;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 64;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  // Operand pair as stored in the FIFO; a sits in the upper half.
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operand_t;

endpackage

// File: rtl/mul_disp_fifo.sv
// Operand-pair FIFO: write visible at the head one cycle after the accept edge.
// Backpressure via wr_rdy_o, a registered not-full that is 0 in reset.
import mul_disp_pkg::*;

module mul_disp_fifo #(
  parameter int W     = 2 * OP_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_vld_i,
  input  logic [W-1:0]             wr_dat_i,
  output logic                     wr_rdy_o,
  input  logic                     rd_i,
  output logic [W-1:0]             rd_dat_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rdy_q, rdy_d;
  logic            do_wr, do_rd;

  assign do_wr = wr_vld_i & rdy_q;
  assign do_rd = rd_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Ready is registered off next occupancy, so write and pop never meet at full.
    rdy_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_ptr_q];
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign wr_rdy_o = rdy_q;

endmodule

// File: rtl/mul_dispatcher.sv
// Queues operand pairs and runs them one at a time on the multiplier start/done/clear handshake, with a watchdog.
// Launch 2 cycles after accept, result 1 cycle after done; no launch while a result is stuck on out_ready=0.
import mul_disp_pkg::*;

module mul_dispatcher #(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_a,
  input  logic [OP_W-1:0]         in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        out_result,
  output logic                    out_err,
  output logic [OP_W-1:0]         mul_multiplier,
  output logic [OP_W-1:0]         mul_multiplicand,
  output logic                    mul_op_start,
  output logic                    mul_op_clear,
  input  logic                    mul_op_done,
  input  logic [RES_W-1:0]        mul_result,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [OP_W-1:0]   opa_q, opa_d;
  logic [OP_W-1:0]   opb_q, opb_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              err_q, err_d;
  logic              vld_q, vld_d;

  logic              fifo_empty;
  logic              fifo_pop;
  logic [2*OP_W-1:0] fifo_rd_dat;
  operand_t          head;
  logic              wd_hit;

  mul_disp_fifo #(
    .W     (2 * OP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .wr_vld_i (in_valid),
    .wr_dat_i ({in_a, in_b}),
    .wr_rdy_o (in_ready),
    .rd_i     (fifo_pop),
    .rd_dat_o (fifo_rd_dat),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign head   = operand_t'(fifo_rd_dat);
  assign wd_hit = (wd_q == WD_LAST);

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only launch when the result slot is free or frees on this edge.
        if (!fifo_empty && (!vld_q || out_ready)) begin
          opa_d   = head.a;
          opb_d   = head.b;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (mul_op_done || wd_hit) begin
          fifo_pop = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        wd_d    = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    err_d = err_q;
    if (vld_q && out_ready) vld_d = 1'b0;
    // Done beats the watchdog when both land on the same cycle.
    if (fifo_pop) begin
      vld_d = 1'b1;
      if (mul_op_done) begin
        res_d = mul_result;
        err_d = 1'b0;
      end else begin
        res_d = '0;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  assign mul_multiplier   = opa_q;
  assign mul_multiplicand = opb_q;
  assign mul_op_start     = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign mul_op_clear     = (state_q == ST_CLEAR);
  assign out_valid        = vld_q;
  assign out_result       = res_q;
  assign out_err          = err_q;
  assign busy             = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mul_dispatcher.sv
// Directed plus randomized bench for mul_dispatcher with a behavioural multiplier whose latency is set per operation.
module tb_mul_dispatcher;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_a, in_b, mul_multiplier, mul_multiplicand;
  logic [63:0] out_result, mul_result;
  logic        mul_op_start, mul_op_clear, mul_op_done, busy;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  mul_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_err(out_err),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
    .mul_op_done(mul_op_done), .mul_result(mul_result),
    .busy(busy), .fifo_count(fifo_count)
  );

  int errors = 0;
  int checks = 0;

  // Per-operation multiplier latency in launch order; -1 means never done.
  int        lat_arr [0:1023];
  logic [9:0] lat_wr = '0;
  logic [9:0] op_idx = '0;
  logic      stub_active, stub_done;
  int        stub_cyc, stub_lat;
  logic [63:0] stub_res;

  assign mul_op_done = stub_done;
  assign mul_result  = stub_res;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    return pa * pb;
  endfunction

  // Done appears in the L-th cycle after the multiplier first sees start and holds until clear.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stub_active <= 1'b0;
      stub_done   <= 1'b0;
      stub_cyc    <= 0;
      stub_lat    <= 0;
      stub_res    <= '0;
    end else if (mul_op_clear) begin
      stub_active <= 1'b0;
      stub_done   <= 1'b0;
    end else if (!stub_active && mul_op_start) begin
      stub_active <= 1'b1;
      stub_cyc    <= 1;
      stub_lat    <= lat_arr[op_idx];
      stub_done   <= (lat_arr[op_idx] == 1);
      op_idx      <= op_idx + 10'd1;
      stub_res    <= prod(mul_multiplier, mul_multiplicand);
    end else if (stub_active && !stub_done) begin
      stub_cyc <= stub_cyc + 1;
      if (stub_lat > 0 && stub_cyc + 1 == stub_lat) stub_done <= 1'b1;
    end
  end

  bit          rand_mode = 1'b0;
  logic [64:0] got_q[$];
  logic [64:0] exp_q[$];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (rand_mode && out_valid && out_ready) got_q.push_back({out_err, out_result});
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input int lat,
                      input int budget, output bit ok);
    int k = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && k < budget) begin
      tick();
      k++;
    end
    ok = in_ready;
    if (ok) begin
      lat_arr[lat_wr] = lat;
      lat_wr = lat_wr + 10'd1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 400) begin
      tick();
      k++;
    end
    chk({tag, "_vld"}, 65'(out_valid), 65'd1);
  endtask

  task automatic get_result(input string tag, input logic [63:0] res, input logic err);
    wait_valid(tag);
    chk({tag, "_res"}, 65'(out_result), 65'(res));
    chk({tag, "_err"}, 65'(out_err), 65'(err));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 65'(in_ready), 65'd0);
    chk({tag, "_out_valid"}, 65'(out_valid), 65'd0);
    chk({tag, "_out_err"}, 65'(out_err), 65'd0);
    chk({tag, "_out_result"}, 65'(out_result), 65'd0);
    chk({tag, "_mplier"}, 65'(mul_multiplier), 65'd0);
    chk({tag, "_mcand"}, 65'(mul_multiplicand), 65'd0);
    chk({tag, "_start"}, 65'(mul_op_start), 65'd0);
    chk({tag, "_clear"}, 65'(mul_op_clear), 65'd0);
    chk({tag, "_busy"}, 65'(busy), 65'd0);
    chk({tag, "_count"}, 65'(fifo_count), 65'd0);
  endtask

  // Cycles from the WAIT entry edge until out_valid is seen; caller must be in the LAUNCH cycle or earlier.
  task automatic measure_wait(output int n);
    int k = 0;
    while (!mul_op_start && k < 20) begin
      tick();
      k++;
    end
    tick();
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 200);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit          ok, saw;
    int          n, k;
    logic [31:0] a, b;
    int          lat, r;

    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #2 reset_n = 1'b1;
    chk("rel_in_ready_0", 65'(in_ready), 65'd0);
    tick();
    chk("rel_in_ready_1", 65'(in_ready), 65'd1);

    // Single 3 x 5
    push(32'd3, 32'd5, 34, 10, ok);
    chk("single_push", 65'(ok), 65'd1);
    chk("single_count", 65'(fifo_count), 65'd1);
    chk("single_start_early", 65'(mul_op_start), 65'd0);
    tick();
    chk("single_start", 65'(mul_op_start), 65'd1);
    chk("single_mplier", 65'(mul_multiplier), 65'd3);
    chk("single_mcand", 65'(mul_multiplicand), 65'd5);
    wait_valid("single");
    chk("single_clear_on", 65'(mul_op_clear), 65'd1);
    chk("single_res", 65'(out_result), 65'h0000_0000_0000_000F);
    chk("single_err", 65'(out_err), 65'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_clear_off", 65'(mul_op_clear), 65'd0);

    // Signed -1 x 2
    push(32'hFFFF_FFFF, 32'h0000_0002, 20, 10, ok);
    chk("signed_push", 65'(ok), 65'd1);
    get_result("signed", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    // Backpressure: result slot held full blocks further launches
    for (int i = 1; i <= 4; i++) begin
      push(32'd7, 32'(i), 34, 10, ok);
      chk($sformatf("bp_push%0d", i), 65'(ok), 65'd1);
    end
    chk("bp_in_ready_low", 65'(in_ready), 65'd0);
    chk("bp_count_full", 65'(fifo_count), 65'd4);
    push(32'd7, 32'd5, 34, 200, ok);
    chk("bp_push5", 65'(ok), 65'd1);
    chk("bp_held_valid", 65'(out_valid), 65'd1);
    push(32'd7, 32'd6, 34, 30, ok);
    chk("bp_push6_refused", 65'(ok), 65'd0);
    saw = 1'b0;
    repeat (10) begin
      tick();
      if (mul_op_start) saw = 1'b1;
    end
    chk("bp_no_launch", 65'(saw), 65'd0);
    chk("bp_count_held", 65'(fifo_count), 65'd4);
    for (int i = 1; i <= 5; i++)
      get_result($sformatf("bp_drain%0d", i), 64'(7 * i), 1'b0);
    chk("bp_empty", 65'(fifo_count), 65'd0);
    chk("bp_idle", 65'(busy), 65'd0);

    // Timeout, then a normal op behind it
    push(32'd11, 32'd13, -1, 10, ok);
    push(32'd2, 32'd3, 34, 10, ok);
    measure_wait(n);
    chk("to_cycles", 65'(n), 65'(TIMEOUT));
    chk("to_err", 65'(out_err), 65'd1);
    chk("to_res", 65'(out_result), 65'd0);
    chk("to_clear_on", 65'(mul_op_clear), 65'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("to_clear_off", 65'(mul_op_clear), 65'd0);
    get_result("after_to", 64'd6, 1'b0);

    // Done on the last watchdog cycle wins
    push(32'h0001_2345, 32'hFFFF_6789, TIMEOUT, 10, ok);
    measure_wait(n);
    chk("coll_cycles", 65'(n), 65'(TIMEOUT));
    chk("coll_err", 65'(out_err), 65'd0);
    chk("coll_res", 65'(out_result), 65'(prod(32'h0001_2345, 32'hFFFF_6789)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in WAIT with two more queued
    push(32'd1, 32'd1, 50, 10, ok);
    push(32'd2, 32'd2, 50, 10, ok);
    push(32'd3, 32'd3, 50, 10, ok);
    repeat (5) tick();
    chk("rst_pre_count", 65'(fifo_count), 65'd3);
    chk("rst_pre_start", 65'(mul_op_start), 65'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #3 reset_n = 1'b1;
    lat_wr = op_idx;
    tick();
    chk("post_rst_in_ready", 65'(in_ready), 65'd1);
    chk("post_rst_count", 65'(fifo_count), 65'd0);
    saw = 1'b0;
    repeat (8) begin
      tick();
      if (mul_op_start || out_valid) saw = 1'b1;
    end
    chk("post_rst_quiet", 65'(saw), 65'd0);

    // Random operands, latencies and downstream stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 9);
      lat = (r == 0) ? -1 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT + 1 : $urandom_range(1, 40);
      push(a, b, lat, 600, ok);
      chk($sformatf("rnd_push%0d", i), 65'(ok), 65'd1);
      if (lat >= 1 && lat <= TIMEOUT) exp_q.push_back({1'b0, prod(a, b)});
      else exp_q.push_back({1'b1, 64'd0});
    end
    k = 0;
    while (got_q.size() < 12 && k < 3000) begin
      tick();
      k++;
    end
    rand_mode = 1'b0;
    out_ready = 1'b0;
    chk("rnd_count", 65'(got_q.size()), 65'd12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      chk($sformatf("rnd_res%0d", i), got_q[i], exp_q[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
